// File: rtl/dma_slice_pkg.sv
// Shared types for the DMA port slice: request FSM states, default widths and
// the request next-state function used by both directions.
package dma_slice_pkg;

    localparam int unsigned DefDataW = 64;
    localparam int unsigned DefAddrW = 32;
    localparam int unsigned DefSizeW = 16;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StRun
    } dma_state_e;

    // busy is the registered copy of the DMA engine's busy flag.
    function automatic dma_state_e req_next_state(input dma_state_e state,
                                                  input logic       areq,
                                                  input logic       busy);
        dma_state_e nxt;
        nxt = state;
        unique case (state)
            StIdle:  if (areq) nxt = StIssue;
            StIssue: nxt = StWait;
            StWait:  if (busy) nxt = StRun;
            StRun:   if (!busy) nxt = StIdle;
            default: nxt = StIdle;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/dma_skid2.sv
// Two-entry beat FIFO with registered source-side ready; no combinational
// path from any input to any output.
module dma_skid2 #(
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] src_data_i,
    input  logic              src_valid_i,
    output logic              src_ready_o,
    output logic [DATA_W-1:0] dst_data_o,
    output logic              dst_valid_o,
    input  logic              dst_ready_i
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic [1:0]        count_d;
    logic              ready_q;
    logic              push;
    logic              pop;

    assign push        = src_valid_i && ready_q;
    assign pop         = dst_valid_o && dst_ready_i;
    assign src_ready_o = ready_q;
    assign dst_valid_o = (count_q != 2'd0);
    assign dst_data_o  = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            ready_q  <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= src_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
            ready_q <= (count_d < 2'd2);
        end
    end

endmodule

// File: rtl/dma_port_slice.sv
// Register slice between a core and a DMA engine: per-direction request FSM plus
// two-entry beat FIFOs. Define DMA_SLICE_STATS_EN to add beat counters.
module dma_port_slice
    import dma_slice_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned SIZE_W = DefSizeW
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     core_rareq_i,
    input  logic [SIZE_W+ADDR_W-1:0] core_rdesc_i,
    output logic                     core_rbusy_o,
    output logic                     dma_rareq_o,
    output logic [SIZE_W+ADDR_W-1:0] dma_rdesc_o,
    input  logic                     dma_rbusy_i,
    input  logic [DATA_W-1:0]        dma_rdata_i,
    input  logic                     dma_rvalid_i,
    output logic                     dma_rready_o,
    output logic [DATA_W-1:0]        core_rdata_o,
    output logic                     core_rvalid_o,
    input  logic                     core_rready_i,
    input  logic                     core_wareq_i,
    input  logic [SIZE_W+ADDR_W-1:0] core_wdesc_i,
    output logic                     core_wbusy_o,
    output logic                     dma_wareq_o,
    output logic [SIZE_W+ADDR_W-1:0] dma_wdesc_o,
    input  logic                     dma_wbusy_i,
    input  logic [DATA_W-1:0]        core_wdata_i,
    input  logic                     core_wvalid_i,
    output logic                     core_wready_o,
    output logic [DATA_W-1:0]        dma_wdata_o,
    output logic                     dma_wvalid_o,
    input  logic                     dma_wready_i
`ifdef DMA_SLICE_STATS_EN
    ,
    output logic [31:0]              stat_rbeats_o,
    output logic [31:0]              stat_wbeats_o
`endif
);

    localparam int unsigned DESC_W = SIZE_W + ADDR_W;

    dma_state_e        rstate_q, rstate_d;
    dma_state_e        wstate_q, wstate_d;
    logic              rbusy_q, wbusy_q;
    logic [DESC_W-1:0] rdesc_q, wdesc_q;

    always_comb begin
        rstate_d = req_next_state(rstate_q, core_rareq_i, rbusy_q);
        wstate_d = req_next_state(wstate_q, core_wareq_i, wbusy_q);
    end

    // Descriptors are captured only on the Idle->Issue edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rstate_q <= StIdle;
            wstate_q <= StIdle;
            rbusy_q  <= 1'b0;
            wbusy_q  <= 1'b0;
            rdesc_q  <= '0;
            wdesc_q  <= '0;
        end else begin
            rstate_q <= rstate_d;
            wstate_q <= wstate_d;
            rbusy_q  <= dma_rbusy_i;
            wbusy_q  <= dma_wbusy_i;
            if (rstate_q == StIdle && core_rareq_i) rdesc_q <= core_rdesc_i;
            if (wstate_q == StIdle && core_wareq_i) wdesc_q <= core_wdesc_i;
        end
    end

    assign dma_rareq_o  = (rstate_q == StIssue);
    assign dma_wareq_o  = (wstate_q == StIssue);
    assign core_rbusy_o = (rstate_q != StIdle);
    assign core_wbusy_o = (wstate_q != StIdle);
    assign dma_rdesc_o  = rdesc_q;
    assign dma_wdesc_o  = wdesc_q;

    dma_skid2 #(
        .DATA_W (DATA_W)
    ) u_rd_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .src_data_i  (dma_rdata_i),
        .src_valid_i (dma_rvalid_i),
        .src_ready_o (dma_rready_o),
        .dst_data_o  (core_rdata_o),
        .dst_valid_o (core_rvalid_o),
        .dst_ready_i (core_rready_i)
    );

    dma_skid2 #(
        .DATA_W (DATA_W)
    ) u_wr_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .src_data_i  (core_wdata_i),
        .src_valid_i (core_wvalid_i),
        .src_ready_o (core_wready_o),
        .dst_data_o  (dma_wdata_o),
        .dst_valid_o (dma_wvalid_o),
        .dst_ready_i (dma_wready_i)
    );

`ifdef DMA_SLICE_STATS_EN
    logic [31:0] stat_rbeats_q, stat_wbeats_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_rbeats_q <= 32'd0;
            stat_wbeats_q <= 32'd0;
        end else begin
            if (core_rvalid_o && core_rready_i) stat_rbeats_q <= stat_rbeats_q + 32'd1;
            if (dma_wvalid_o && dma_wready_i)   stat_wbeats_q <= stat_wbeats_q + 32'd1;
        end
    end

    assign stat_rbeats_o = stat_rbeats_q;
    assign stat_wbeats_o = stat_wbeats_q;
`endif

endmodule

// File: tb/tb_dma_port_slice.sv
// Directed self-checking bench for dma_port_slice; covers the stats counters
// when DMA_SLICE_STATS_EN is defined.
module tb_dma_port_slice;

    localparam int unsigned DW = 64;
    localparam int unsigned DESCW = 48;

    logic             clk = 1'b0;
    logic             rst;
    logic             core_rareq, core_wareq;
    logic [DESCW-1:0] core_rdesc, core_wdesc, dma_rdesc, dma_wdesc;
    logic             core_rbusy, core_wbusy, dma_rareq, dma_wareq;
    logic             dma_rbusy, dma_wbusy;
    logic [DW-1:0]    dma_rdata, core_rdata, core_wdata, dma_wdata;
    logic             dma_rvalid, dma_rready, core_rvalid, core_rready;
    logic             core_wvalid, core_wready, dma_wvalid, dma_wready;
`ifdef DMA_SLICE_STATS_EN
    logic [31:0]      stat_rbeats, stat_wbeats;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    dma_port_slice dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .core_rareq_i  (core_rareq),
        .core_rdesc_i  (core_rdesc),
        .core_rbusy_o  (core_rbusy),
        .dma_rareq_o   (dma_rareq),
        .dma_rdesc_o   (dma_rdesc),
        .dma_rbusy_i   (dma_rbusy),
        .dma_rdata_i   (dma_rdata),
        .dma_rvalid_i  (dma_rvalid),
        .dma_rready_o  (dma_rready),
        .core_rdata_o  (core_rdata),
        .core_rvalid_o (core_rvalid),
        .core_rready_i (core_rready),
        .core_wareq_i  (core_wareq),
        .core_wdesc_i  (core_wdesc),
        .core_wbusy_o  (core_wbusy),
        .dma_wareq_o   (dma_wareq),
        .dma_wdesc_o   (dma_wdesc),
        .dma_wbusy_i   (dma_wbusy),
        .core_wdata_i  (core_wdata),
        .core_wvalid_i (core_wvalid),
        .core_wready_o (core_wready),
        .dma_wdata_o   (dma_wdata),
        .dma_wvalid_o  (dma_wvalid),
        .dma_wready_i  (dma_wready)
`ifdef DMA_SLICE_STATS_EN
        ,
        .stat_rbeats_o (stat_rbeats),
        .stat_wbeats_o (stat_wbeats)
`endif
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        core_rareq = 1'b0; core_rdesc = '0; dma_rbusy = 1'b0;
        dma_rdata = '0; dma_rvalid = 1'b0; core_rready = 1'b0;
        core_wareq = 1'b0; core_wdesc = '0; dma_wbusy = 1'b0;
        core_wdata = '0; core_wvalid = 1'b0; dma_wready = 1'b0;
        tick(); tick();
        vec_cnt++;
        if ({core_rbusy, dma_rareq, dma_rready, core_rvalid, core_wbusy, dma_wareq,
             core_wready, dma_wvalid} !== 8'h00) begin
            err_cnt++;
            $display("FAIL reset_ctrl: got %b want 00000000", {core_rbusy, dma_rareq,
                     dma_rready, core_rvalid, core_wbusy, dma_wareq, core_wready, dma_wvalid});
        end
        vec_cnt++;
        if ({dma_rdesc, dma_wdesc, core_rdata, dma_wdata} !== '0) begin
            err_cnt++;
            $display("FAIL reset_data: got %h %h %h %h want 0", dma_rdesc, dma_wdesc,
                     core_rdata, dma_wdata);
        end
        rst = 1'b0;
        tick();
        vec_cnt++;
        if ({dma_rready, core_wready} !== 2'b11) begin
            err_cnt++;
            $display("FAIL reset_release_ready: got %b want 11", {dma_rready, core_wready});
        end
    endtask

    task automatic test_read_req();
        core_rareq = 1'b1;
        core_rdesc = {16'd64, 32'h1000_0000};
        tick();
        core_rareq = 1'b0;
        vec_cnt++;
        if ({dma_rareq, core_rbusy, dma_rdesc} !== {2'b11, 16'd64, 32'h1000_0000}) begin
            err_cnt++;
            $display("FAIL rreq_issue: got areq=%b busy=%b desc=%h want 1 1 0040_1000_0000",
                     dma_rareq, core_rbusy, dma_rdesc);
        end
        // Now in Wait: second request must be ignored.
        dma_rbusy = 1'b1;
        core_rareq = 1'b1;
        core_rdesc = {16'd8, 32'h2000_0000};
        tick();
        core_rareq = 1'b0;
        vec_cnt++;
        if ({dma_rareq, core_rbusy, dma_rdesc} !== {2'b01, 16'd64, 32'h1000_0000}) begin
            err_cnt++;
            $display("FAIL rreq_ignore_wait: got areq=%b busy=%b desc=%h want 0 1 0040_1000_0000",
                     dma_rareq, core_rbusy, dma_rdesc);
        end
        tick();
        dma_rbusy = 1'b0;
        core_rareq = 1'b1;
        tick();
        core_rareq = 1'b0;
        vec_cnt++;
        if ({dma_rareq, core_rbusy, dma_rdesc} !== {2'b01, 16'd64, 32'h1000_0000}) begin
            err_cnt++;
            $display("FAIL rreq_ignore_run: got areq=%b busy=%b desc=%h want 0 1 0040_1000_0000",
                     dma_rareq, core_rbusy, dma_rdesc);
        end
        tick();
        vec_cnt++;
        if ({dma_rareq, core_rbusy} !== 2'b00) begin
            err_cnt++;
            $display("FAIL rreq_done: got areq=%b busy=%b want 0 0", dma_rareq, core_rbusy);
        end
    endtask

    task automatic test_write_req();
        core_wareq = 1'b1;
        core_wdesc = {16'd32, 32'h0000_4000};
        tick();
        core_wareq = 1'b0;
        vec_cnt++;
        if ({dma_wareq, core_wbusy, dma_wdesc} !== {2'b11, 16'd32, 32'h0000_4000}) begin
            err_cnt++;
            $display("FAIL wreq_issue: got areq=%b busy=%b desc=%h want 1 1 0020_0000_4000",
                     dma_wareq, core_wbusy, dma_wdesc);
        end
        dma_wbusy = 1'b1;
        tick();
        vec_cnt++;
        if ({dma_wareq, core_wbusy} !== 2'b01) begin
            err_cnt++;
            $display("FAIL wreq_one_cycle: got areq=%b busy=%b want 0 1", dma_wareq, core_wbusy);
        end
        tick();
        dma_wbusy = 1'b0;
        tick();
        vec_cnt++;
        if (core_wbusy !== 1'b1) begin
            err_cnt++;
            $display("FAIL wreq_busy_lag: got busy=%b want 1", core_wbusy);
        end
        tick();
        vec_cnt++;
        if (core_wbusy !== 1'b0) begin
            err_cnt++;
            $display("FAIL wreq_done: got busy=%b want 0", core_wbusy);
        end
    endtask

    task automatic test_read_stream();
        core_rready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dma_rdata = DW'(i);
            dma_rvalid = 1'b1;
            tick();
            vec_cnt++;
            if ({core_rvalid, dma_rready, core_rdata} !== {2'b11, DW'(i)}) begin
                err_cnt++;
                $display("FAIL rstream_beat%0d: got valid=%b ready=%b data=%0d want 1 1 %0d",
                         i, core_rvalid, dma_rready, core_rdata, i);
            end
        end
        dma_rvalid = 1'b0;
        tick();
        vec_cnt++;
        if (core_rvalid !== 1'b0) begin
            err_cnt++;
            $display("FAIL rstream_empty: got valid=%b want 0", core_rvalid);
        end
    endtask

    task automatic test_backpressure();
        core_rready = 1'b0;
        dma_rvalid = 1'b1;
        dma_rdata = 64'd10;
        tick();
        vec_cnt++;
        if (dma_rready !== 1'b1) begin
            err_cnt++;
            $display("FAIL bp_one_held: got ready=%b want 1", dma_rready);
        end
        dma_rdata = 64'd11;
        tick();
        dma_rdata = 64'd12;
        vec_cnt++;
        if ({dma_rready, core_rvalid, core_rdata} !== {2'b01, 64'd10}) begin
            err_cnt++;
            $display("FAIL bp_full: got ready=%b valid=%b data=%0d want 0 1 10",
                     dma_rready, core_rvalid, core_rdata);
        end
        tick();
        vec_cnt++;
        if ({dma_rready, core_rdata} !== {1'b0, 64'd10}) begin
            err_cnt++;
            $display("FAIL bp_stall: got ready=%b data=%0d want 0 10", dma_rready, core_rdata);
        end
        core_rready = 1'b1;
        tick();
        vec_cnt++;
        if ({dma_rready, core_rvalid, core_rdata} !== {2'b11, 64'd11}) begin
            err_cnt++;
            $display("FAIL bp_drain1: got ready=%b valid=%b data=%0d want 1 1 11",
                     dma_rready, core_rvalid, core_rdata);
        end
        tick();
        dma_rvalid = 1'b0;
        vec_cnt++;
        if ({core_rvalid, core_rdata} !== {1'b1, 64'd12}) begin
            err_cnt++;
            $display("FAIL bp_resume: got valid=%b data=%0d want 1 12", core_rvalid, core_rdata);
        end
        tick();
        vec_cnt++;
        if (core_rvalid !== 1'b0) begin
            err_cnt++;
            $display("FAIL bp_empty: got valid=%b want 0", core_rvalid);
        end
    endtask

    task automatic test_write_stream();
        dma_wready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            core_wdata = 64'hA0 + DW'(i);
            core_wvalid = 1'b1;
            tick();
            vec_cnt++;
            if ({dma_wvalid, core_wready, dma_wdata} !== {2'b11, 64'hA0 + DW'(i)}) begin
                err_cnt++;
                $display("FAIL wstream_beat%0d: got valid=%b ready=%b data=%h want 1 1 %h",
                         i, dma_wvalid, core_wready, dma_wdata, 64'hA0 + DW'(i));
            end
        end
        core_wvalid = 1'b0;
        tick();
    endtask

    task automatic test_reset_midburst();
        dma_wready = 1'b0;
        core_rareq = 1'b1;
        core_rdesc = {16'd4, 32'h0000_0100};
        core_wvalid = 1'b1;
        core_wdata = 64'h55;
        tick();
        core_rareq = 1'b0;
        core_wdata = 64'h66;
        tick();
        core_wvalid = 1'b0;
        vec_cnt++;
        if ({dma_wvalid, core_wready, core_rbusy, dma_wdata} !== {3'b101, 64'h55}) begin
            err_cnt++;
            $display("FAIL mid_buffered: got valid=%b ready=%b rbusy=%b data=%h want 1 0 1 55",
                     dma_wvalid, core_wready, core_rbusy, dma_wdata);
        end
        rst = 1'b1;
        tick();
        vec_cnt++;
        if ({dma_wvalid, core_rbusy, core_wbusy, dma_rdesc} !== '0) begin
            err_cnt++;
            $display("FAIL mid_reset: got valid=%b rbusy=%b wbusy=%b desc=%h want 0 0 0 0",
                     dma_wvalid, core_rbusy, core_wbusy, dma_rdesc);
        end
        rst = 1'b0;
        dma_wready = 1'b1;
        tick();
        vec_cnt++;
        if ({dma_wvalid, core_wready} !== 2'b01) begin
            err_cnt++;
            $display("FAIL mid_release: got valid=%b ready=%b want 0 1", dma_wvalid, core_wready);
        end
        tick();
        vec_cnt++;
        if (dma_wvalid !== 1'b0) begin
            err_cnt++;
            $display("FAIL mid_no_stale: got valid=%b want 0", dma_wvalid);
        end
    endtask

`ifdef DMA_SLICE_STATS_EN
    task automatic test_stats();
        force dut.stat_rbeats_q = 32'hFFFF_FFFF;
        #1;
        release dut.stat_rbeats_q;
        core_rready = 1'b1;
        dma_rvalid = 1'b1;
        dma_rdata = 64'd1;
        tick();
        tick();
        tick();
        tick();
        dma_rvalid = 1'b0;
        tick();
        vec_cnt++;
        if ({stat_rbeats, stat_wbeats} !== {32'd3, 32'd0}) begin
            err_cnt++;
            $display("FAIL stats_wrap: got r=%0d w=%0d want 3 0", stat_rbeats, stat_wbeats);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_read_req();
        test_write_req();
        test_read_stream();
        test_backpressure();
        test_write_stream();
        test_reset_midburst();
`ifdef DMA_SLICE_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
